// File: rtl/distribute_tree_pipe_if.sv
// Bus bundle for distribute_tree_pipe: one input word with a lane mask in,
// per-lane valid/data out.
interface distribute_tree_pipe_if #(
  parameter int NUM_OUTPUT_DATA = 16,
  parameter int DATA_WIDTH      = 8
) ();
  logic                                  i_valid;
  logic [DATA_WIDTH-1:0]                 i_data_bus;
  logic [NUM_OUTPUT_DATA-1:0]            i_dest_bus;
  logic                                  i_en;
  logic [NUM_OUTPUT_DATA-1:0]            o_valid;
  logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus;

  modport master (
    output i_valid, i_data_bus, i_dest_bus, i_en,
    input  o_valid, o_data_bus
  );

  modport slave (
    input  i_valid, i_data_bus, i_dest_bus, i_en,
    output o_valid, o_data_bus
  );
endinterface

// File: rtl/distribute_tree_pipe.sv
// Pipelined binary multicast tree: one word plus lane mask in per cycle, the word
// lands on every masked lane NUM_LEVEL enabled cycles later (one register per level).
module distribute_tree_pipe #(
  parameter int NUM_OUTPUT_DATA = 16,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  distribute_tree_pipe_if.slave bus
);
  localparam int NUM_LEVEL = (NUM_OUTPUT_DATA > 1) ? $clog2(NUM_OUTPUT_DATA) : 1;

  // Leaf-coverage mask of node idx at a level whose nodes each span `span` leaves.
  function automatic logic [NUM_OUTPUT_DATA-1:0] node_range(input int span, input int idx);
    logic [NUM_OUTPUT_DATA-1:0] r;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      if ((j / span) == idx) r[j] = 1'b1;
      else                   r[j] = 1'b0;
    end
    return r;
  endfunction

  // The destination mask travels alongside the word; the leaf level needs none of its own.
  for (genvar l = 0; l < NUM_LEVEL; l++) begin : g_msk
    logic [NUM_OUTPUT_DATA-1:0] msk;
    if (l == 0) begin : g_src
      assign msk = bus.i_dest_bus;
    end else begin : g_src
      logic [NUM_OUTPUT_DATA-1:0] msk_d, msk_q;

      // Mask stage advances with the tree.
      always_comb begin
        msk_d = msk_q;
        if (bus.i_en) msk_d = g_msk[l-1].msk;
        else          msk_d = msk_q;
      end

      // Mask stage register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) msk_q <= {NUM_OUTPUT_DATA{1'b0}};
        else        msk_q <= msk_d;
      end

      assign msk = msk_q;
    end
  end

  for (genvar l = 0; l <= NUM_LEVEL; l++) begin : g_lvl
    localparam int SPAN  = 1 << (NUM_LEVEL - l);
    localparam int NODES = (NUM_OUTPUT_DATA + SPAN - 1) / SPAN;
    logic [NODES-1:0]                 vld;
    logic [NODES-1:0][DATA_WIDTH-1:0] dat;

    if (l == 0) begin : g_node
      assign vld[0] = bus.i_valid;
      assign dat[0] = bus.i_data_bus;
    end else begin : g_node
      logic [NODES-1:0]                 vld_d, vld_q;
      logic [NODES-1:0][DATA_WIDTH-1:0] dat_d, dat_q;

      // Child m of parent m/2 takes the word only if some destination lies in its
      // leaf range; otherwise it carries an all-zero dummy.
      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (bus.i_en) begin
          for (int m = 0; m < NODES; m++) begin
            if (g_lvl[l-1].vld[m/2] && (|(g_msk[l-1].msk & node_range(SPAN, m)))) begin
              vld_d[m] = 1'b1;
              dat_d[m] = g_lvl[l-1].dat[m/2];
            end else begin
              vld_d[m] = 1'b0;
              dat_d[m] = {DATA_WIDTH{1'b0}};
            end
          end
        end else begin
          vld_d = vld_q;
          dat_d = dat_q;
        end
      end

      // Node registers for this level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= {NODES{1'b0}};
          dat_q <= {(NODES*DATA_WIDTH){1'b0}};
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign vld = vld_q;
      assign dat = dat_q;
    end
  end

  assign bus.o_valid    = g_lvl[NUM_LEVEL].vld;
  assign bus.o_data_bus = g_lvl[NUM_LEVEL].dat;
endmodule

// File: tb/tb_distribute_tree_pipe.sv
// Self-checking bench: a 16-lane/8-bit tree and a 5-lane/4-bit tree driven from the
// same stimulus, checked against a queue-based latency model of the delivery rule.
module tb_distribute_tree_pipe;
  localparam int L16 = 4;
  localparam int L5  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  distribute_tree_pipe_if #(.NUM_OUTPUT_DATA(16), .DATA_WIDTH(8)) if16 ();
  distribute_tree_pipe_if #(.NUM_OUTPUT_DATA(5),  .DATA_WIDTH(4)) if5 ();

  distribute_tree_pipe #(.NUM_OUTPUT_DATA(16), .DATA_WIDTH(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16));
  distribute_tree_pipe #(.NUM_OUTPUT_DATA(5), .DATA_WIDTH(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5));

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic [15:0] m;
  } rec_t;

  rec_t q16[$];
  rec_t q5[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [15:0] ev16(rec_t r);
    return r.v ? r.m : 16'h0000;
  endfunction

  function automatic logic [127:0] ed16(rec_t r);
    logic [127:0] x;
    x = 128'h0;
    for (int j = 0; j < 16; j++) if (r.v && r.m[j]) x[j*8 +: 8] = r.d;
    return x;
  endfunction

  function automatic logic [4:0] ev5(rec_t r);
    return r.v ? r.m[4:0] : 5'b00000;
  endfunction

  function automatic logic [19:0] ed5(rec_t r);
    logic [19:0] x;
    x = 20'h0;
    for (int j = 0; j < 5; j++) if (r.v && r.m[j]) x[j*4 +: 4] = r.d[3:0];
    return x;
  endfunction

  task automatic model_reset();
    q16.delete();
    q5.delete();
    for (int i = 0; i < L16; i++) q16.push_back('0);
    for (int i = 0; i < L5; i++)  q5.push_back('0);
  endtask

  // Drive one cycle of input to both trees, advance the model on an enabled edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [15:0] m, input logic en);
    rec_t r;
    rec_t dummy;
    if16.i_valid = v;  if16.i_data_bus = d;      if16.i_dest_bus = m;      if16.i_en = en;
    if5.i_valid  = v;  if5.i_data_bus  = d[3:0]; if5.i_dest_bus  = m[4:0]; if5.i_en  = en;
    @(posedge clk);
    if (rst_n && en) begin
      r.v = v; r.d = d; r.m = m;
      q16.push_back(r); dummy = q16.pop_front();
      q5.push_back(r);  dummy = q5.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    if16.i_valid = 1'b1; if16.i_data_bus = 8'hFF; if16.i_dest_bus = 16'hFFFF; if16.i_en = 1'b1;
    if5.i_valid  = 1'b1; if5.i_data_bus  = 4'hF;  if5.i_dest_bus  = 5'h1F;    if5.i_en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({if16.o_valid, if16.o_data_bus} !== 144'h0)
      $display("FAIL reset16 got %h required 0", {if16.o_valid, if16.o_data_bus});
    else n_pass++;
    n_total++;
    if ({if5.o_valid, if5.o_data_bus} !== 25'h0)
      $display("FAIL reset5 got %h required 0", {if5.o_valid, if5.o_data_bus});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_broadcast();
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) step(1'b1, 8'hA5, 16'hFFFF, 1'b1);
      else        step(1'b0, 8'h00, 16'h0000, 1'b1);
      n_total++;
      if ({if16.o_valid, if16.o_data_bus} !== {ev16(q16[0]), ed16(q16[0])})
        $display("FAIL bcast16 k=%0d got %h required %h", k, {if16.o_valid, if16.o_data_bus}, {ev16(q16[0]), ed16(q16[0])});
      else n_pass++;
      n_total++;
      if ({if5.o_valid, if5.o_data_bus} !== {ev5(q5[0]), ed5(q5[0])})
        $display("FAIL bcast5 k=%0d got %h required %h", k, {if5.o_valid, if5.o_data_bus}, {ev5(q5[0]), ed5(q5[0])});
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if (if16.o_valid !== 16'hFFFF || if16.o_data_bus !== {16{8'hA5}})
          $display("FAIL bcast16_lat got %h/%h required ffff/all a5", if16.o_valid, if16.o_data_bus);
        else n_pass++;
      end
      if (k == 3) begin
        n_total++;
        if (if5.o_valid !== 5'h1F || if5.o_data_bus !== {5{4'h5}})
          $display("FAIL bcast5_lat got %h/%h required 1f/55555", if5.o_valid, if5.o_data_bus);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stream();
    logic [7:0]  wd [3];
    logic [15:0] wm [3];
    wd[0] = 8'h11; wm[0] = 16'h0001;
    wd[1] = 8'h22; wm[1] = 16'h8000;
    wd[2] = 8'h33; wm[2] = 16'h00F0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 3) step(1'b1, wd[k-1], wm[k-1], 1'b1);
      else        step(1'b0, 8'h00, 16'h0000, 1'b1);
      n_total++;
      if ({if16.o_valid, if16.o_data_bus} !== {ev16(q16[0]), ed16(q16[0])})
        $display("FAIL stream16 k=%0d got %h required %h", k, {if16.o_valid, if16.o_data_bus}, {ev16(q16[0]), ed16(q16[0])});
      else n_pass++;
      n_total++;
      if ({if5.o_valid, if5.o_data_bus} !== {ev5(q5[0]), ed5(q5[0])})
        $display("FAIL stream5 k=%0d got %h required %h", k, {if5.o_valid, if5.o_data_bus}, {ev5(q5[0]), ed5(q5[0])});
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if ({if16.o_valid, if16.o_data_bus} !== {16'h0001, 120'h0, 8'h11})
          $display("FAIL stream_lane0 got %h/%h required 0001/..11", if16.o_valid, if16.o_data_bus);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if ({if16.o_valid, if16.o_data_bus} !== {16'h8000, 8'h22, 120'h0})
          $display("FAIL stream_lane15 got %h/%h required 8000/22..", if16.o_valid, if16.o_data_bus);
        else n_pass++;
      end
      if (k == 6) begin
        n_total++;
        if ({if16.o_valid, if16.o_data_bus} !== {16'h00F0, 64'h0, 32'h33333333, 32'h0})
          $display("FAIL stream_lanes4_7 got %h/%h required 00f0/33 on lanes 4-7", if16.o_valid, if16.o_data_bus);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int hits;
    hits = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1)                step(1'b1, 8'h5C, 16'h0100, 1'b1);
      else if (k >= 3 && k <= 5) step(1'b1, 8'hEE, 16'hFFFF, 1'b0);
      else                       step(1'b0, 8'h00, 16'h0000, 1'b1);
      if (if16.o_valid[8] === 1'b1) hits++;
      n_total++;
      if ({if16.o_valid, if16.o_data_bus} !== {ev16(q16[0]), ed16(q16[0])})
        $display("FAIL stall16 k=%0d got %h required %h", k, {if16.o_valid, if16.o_data_bus}, {ev16(q16[0]), ed16(q16[0])});
      else n_pass++;
      n_total++;
      if ({if5.o_valid, if5.o_data_bus} !== {ev5(q5[0]), ed5(q5[0])})
        $display("FAIL stall5 k=%0d got %h required %h", k, {if5.o_valid, if5.o_data_bus}, {ev5(q5[0]), ed5(q5[0])});
      else n_pass++;
      if (k == 7) begin
        n_total++;
        if (if16.o_valid !== 16'h0100 || if16.o_data_bus[64 +: 8] !== 8'h5C)
          $display("FAIL stall_resume got %h/%h required 0100/5c", if16.o_valid, if16.o_data_bus[64 +: 8]);
        else n_pass++;
      end
    end
    n_total++;
    if (hits !== 1) $display("FAIL stall_once got %0d required 1", hits);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 8'h71, 16'h0004, 1'b1);
    step(1'b1, 8'h72, 16'h0020, 1'b1);
    step(1'b1, 8'h73, 16'hFFFF, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({if16.o_valid, if16.o_data_bus} !== 144'h0)
      $display("FAIL midreset16 got %h required 0", {if16.o_valid, if16.o_data_bus});
    else n_pass++;
    n_total++;
    if ({if5.o_valid, if5.o_data_bus} !== 25'h0)
      $display("FAIL midreset5 got %h required 0", {if5.o_valid, if5.o_data_bus});
    else n_pass++;
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) step(1'b1, 8'h4D, 16'h0002, 1'b1);
      else        step(1'b0, 8'h00, 16'h0000, 1'b1);
      n_total++;
      if ({if16.o_valid, if16.o_data_bus} !== {ev16(q16[0]), ed16(q16[0])})
        $display("FAIL postreset16 k=%0d got %h required %h", k, {if16.o_valid, if16.o_data_bus}, {ev16(q16[0]), ed16(q16[0])});
      else n_pass++;
      n_total++;
      if ({if5.o_valid, if5.o_data_bus} !== {ev5(q5[0]), ed5(q5[0])})
        $display("FAIL postreset5 k=%0d got %h required %h", k, {if5.o_valid, if5.o_data_bus}, {ev5(q5[0]), ed5(q5[0])});
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if ({if16.o_valid, if16.o_data_bus} !== {16'h0002, 112'h0, 8'h4D, 8'h00})
          $display("FAIL postreset_lane1 got %h/%h required 0002/4d on lane1", if16.o_valid, if16.o_data_bus);
        else n_pass++;
      end
    end
  endtask

  task automatic test_nonpow2();
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) step(1'b1, 8'h99, 16'h0011, 1'b1);
      else        step(1'b0, 8'h00, 16'h0000, 1'b1);
      n_total++;
      if ({if5.o_valid, if5.o_data_bus} !== {ev5(q5[0]), ed5(q5[0])})
        $display("FAIL np2_model k=%0d got %h required %h", k, {if5.o_valid, if5.o_data_bus}, {ev5(q5[0]), ed5(q5[0])});
      else n_pass++;
      if (k == 3) begin
        n_total++;
        if (if5.o_valid !== 5'b10001 || if5.o_data_bus !== {4'h9, 12'h000, 4'h9})
          $display("FAIL np2_lanes got %b/%h required 10001/90009", if5.o_valid, if5.o_data_bus);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_mask();
    for (int k = 1; k <= 7; k++) begin
      if (k == 1)      step(1'b1, 8'hFF, 16'h0000, 1'b1);
      else if (k == 2) step(1'b0, 8'hFF, 16'hFFFF, 1'b1);
      else             step(1'b0, 8'h00, 16'h0000, 1'b1);
      n_total++;
      if (if16.o_valid !== 16'h0000 || if16.o_data_bus !== 128'h0)
        $display("FAIL zmask16 k=%0d got %h/%h required 0/0", k, if16.o_valid, if16.o_data_bus);
      else n_pass++;
      n_total++;
      if (if5.o_valid !== 5'h00)
        $display("FAIL zmask5 k=%0d got %h required 0", k, if5.o_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic        v, en;
    logic [7:0]  d;
    logic [15:0] m;
    for (int k = 0; k < 400; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom_range(1, 255));
      m  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      en = (k < 80) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step(v, d, m, en);
      n_total++;
      if ({if16.o_valid, if16.o_data_bus} !== {ev16(q16[0]), ed16(q16[0])})
        $display("FAIL rand16 k=%0d got %h required %h", k, {if16.o_valid, if16.o_data_bus}, {ev16(q16[0]), ed16(q16[0])});
      else n_pass++;
      n_total++;
      if ({if5.o_valid, if5.o_data_bus} !== {ev5(q5[0]), ed5(q5[0])})
        $display("FAIL rand5 k=%0d got %h required %h", k, {if5.o_valid, if5.o_data_bus}, {ev5(q5[0]), ed5(q5[0])});
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_broadcast();
    test_stream();
    test_stall();
    test_reset_midflight();
    test_nonpow2();
    test_zero_mask();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/distribute_tree_pipe.md
Name: distribute_tree_pipe

Overview:
- Pipelined binary multicast distribution tree; the fan-out counterpart of the team's reduction trees.
- Takes one DATA_WIDTH word plus an NUM_OUTPUT_DATA-bit destination mask per cycle.
- Delivers the word to every masked output lane after a fixed latency, one register stage per tree level.
- Sits in front of PE arrays to feed operands from a single buffer port into many consumers.

Parameters:
- NUM_OUTPUT_DATA, 16, number of output lanes; any integer >= 1, not required to be a power of 2.
- DATA_WIDTH, 8, width of one data word.
- NUM_LEVEL, derived localparam: max(1, $clog2(NUM_OUTPUT_DATA)); equals the pipeline depth.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input word valid.
- i_data_bus  input  DATA_WIDTH  input word.
- i_dest_bus  input  NUM_OUTPUT_DATA  destination mask; bit j set delivers the word to lane j.
- i_en  input  1  pipeline advance enable; 0 stalls the whole tree.
- o_valid  output  NUM_OUTPUT_DATA  per-lane valid.
- o_data_bus  output  NUM_OUTPUT_DATA*DATA_WIDTH  lane j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Structure:
  - The root is a combinational split of the inputs.
  - A node at level l (1..NUM_LEVEL), index m, covers leaves [m*2^(NUM_LEVEL-l), min((m+1)*2^(NUM_LEVEL-l), NUM_OUTPUT_DATA) - 1].
  - Nodes with an empty range are not instantiated.
  - Each node registers a valid bit, the data word, and the mask slice for its range.
- Node rule: a node's next valid = parent valid AND OR(mask bits in its range).
  - If the next valid is 1, next data = parent data; otherwise next data = 0 (dummy data is all-zero).
  - A parent with only one child forwards to that child only (odd or edge node).
- Leaf registers (level NUM_LEVEL) drive o_valid and o_data_bus directly. There is no combinational path from inputs to outputs.
- Latency: exactly NUM_LEVEL cycles. A word accepted at edge t appears on its lanes after edge t+NUM_LEVEL-1 and is stable until the next advancing edge.
- Throughput: one word per cycle while i_en=1. Back-to-back words with different masks do not interfere.
- Functional equivalence: o_valid[j] at output slot k = i_valid & i_dest_bus[j] at input slot k. Lane data equals the input word where valid, and 0 otherwise.
- Stall: when i_en=0, every register holds its value, including outputs. Inputs are ignored that cycle and are not queued. When i_en returns to 1, the pipeline resumes with no loss or duplication of in-flight words.
- i_valid=1 with i_dest_bus=0: the word is dropped; no lane ever asserts valid for it.
- i_valid=0 with a nonzero mask: nothing delivered; the mask is ignored.
- Reset: rst_n low asynchronously clears all node and leaf registers. All o_valid=0 and o_data_bus=0 immediately, held while rst_n=0.
  - Reset mid-operation discards all in-flight words.
  - The first input sampled after release is delivered with normal latency.
- NUM_OUTPUT_DATA=1: a single register stage; latency 1.

Test Plan:
- N=16, W=8; broadcast: i_valid=1, data=0xA5, mask=0xFFFF, i_en=1 for one cycle -> 4 cycles later all 16 o_valid=1 and every lane=0xA5 for one cycle, then all 0.
- Unicast/multicast stream:
  - Consecutive cycles send (0x11, mask 0x0001), (0x22, mask 0x8000), (0x33, mask 0x00F0).
  - Required: lane0=0x11; next cycle lane15=0x22; next cycle lanes4-7=0x33. All other lanes 0/invalid in each of those cycles.
- Stall:
  - Send 0x5C to mask 0x0100, then drop i_en for 3 cycles after 2 cycles.
  - Required: outputs frozen during the stall; lane8=0x5C appears exactly once, 2 enabled cycles after i_en returns. A new input presented during the stall is never delivered.
- Reset mid-flight: three words in the pipe, pulse rst_n low between edges -> outputs drop to 0 immediately; no stale word ever emerges; a post-reset word with mask 0x0002 arrives on lane1 after 4 cycles.
- Non-power-of-two, N=5, W=4 (NUM_LEVEL=3): mask 0b10001, data 0x9 -> after 3 cycles lanes 0 and 4 = 0x9, valid; lanes 1-3 invalid/0.
- Zero-mask and invalid input: i_valid=1 with mask 0, and i_valid=0 with mask 0xFFFF -> o_valid stays 0x0000 throughout.
